// File: rtl/label_argmax_stream_pkg.sv
// Shared types and helpers for the streaming top-2 label selector.
package label_argmax_stream_pkg;

  // Frame controller states: collecting scores, or presenting a result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Widest score the compare helper handles; callers extend into this width.
  localparam int unsigned MAX_SCORE_W = 64;

  // Smallest label index width able to number n labels.
  function automatic int unsigned label_w_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Strict greater-than on pre-extended scores (sign- or zero-extended by caller).
  function automatic logic score_gt(input logic [MAX_SCORE_W-1:0] a,
                                    input logic [MAX_SCORE_W-1:0] b,
                                    input logic                   sgn);
    if (sgn) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/label_argmax_stream_top2_tracker.sv
// Registered best / second-best score tracker for one frame of scores.
module top2_tracker
  import label_argmax_stream_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned LABEL_W     = 4,
  parameter bit          SIGNED_MODE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               beat,
  input  logic               first,
  input  logic [N-1:0]       x,
  input  logic [LABEL_W-1:0] idx,
  output logic [N-1:0]       best,
  output logic [LABEL_W-1:0] best_idx,
  output logic [N-1:0]       second,
  output logic [LABEL_W-1:0] second_idx
);

  logic                   second_valid;
  logic [MAX_SCORE_W-1:0] x_ext, best_ext, second_ext;
  logic                   gt_best, gt_second;

  // Extend scores to the helper width so one compare serves both modes.
  always_comb begin
    if (SIGNED_MODE) begin
      x_ext      = MAX_SCORE_W'($signed(x));
      best_ext   = MAX_SCORE_W'($signed(best));
      second_ext = MAX_SCORE_W'($signed(second));
    end else begin
      x_ext      = MAX_SCORE_W'(x);
      best_ext   = MAX_SCORE_W'(best);
      second_ext = MAX_SCORE_W'(second);
    end
    gt_best   = score_gt(x_ext, best_ext, SIGNED_MODE);
    gt_second = score_gt(x_ext, second_ext, SIGNED_MODE);
  end

  // Strict compares: on ties the earlier (lower-index) entry is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best         <= '0;
      best_idx     <= '0;
      second       <= '0;
      second_idx   <= '0;
      second_valid <= 1'b0;
    end else if (beat) begin
      if (first) begin
        best         <= x;
        best_idx     <= idx;
        second       <= '0;
        second_idx   <= '0;
        second_valid <= 1'b0;
      end else if (gt_best) begin
        second       <= best;
        second_idx   <= best_idx;
        second_valid <= 1'b1;
        best         <= x;
        best_idx     <= idx;
      end else if (!second_valid || gt_second) begin
        second       <= x;
        second_idx   <= idx;
        second_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/label_argmax_stream.sv
// Streaming argmax: consumes NUM_LABELS scores per frame and reports the
// top label, runner-up label, top score and the top-to-second margin.
module label_argmax_stream
  import label_argmax_stream_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned NUM_LABELS  = 10,
  parameter int unsigned LABEL_W     = 4,
  parameter bit          SIGNED_MODE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_label,
  output logic [LABEL_W-1:0] out_second,
  output logic [N-1:0]       out_max,
  output logic [N-1:0]       out_margin,
  output logic               out_err
);

  localparam int unsigned MIN_LABEL_W = label_w_for(NUM_LABELS);

  if (LABEL_W < MIN_LABEL_W) begin : g_bad_label_w
    $error("label_argmax_stream: LABEL_W too narrow for NUM_LABELS");
  end

  state_t             state, state_nxt;
  logic               run;
  logic [LABEL_W-1:0] idx;
  logic               err;
  logic               beat, last_beat, first_beat;
  logic [N-1:0]       best, second;

  assign beat       = in_valid && in_ready;
  assign last_beat  = (idx == LABEL_W'(NUM_LABELS - 1));
  assign first_beat = (idx == '0);

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Frame controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; in_ready depends only on registered state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = run;
        if (beat && last_beat) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Beat position; frame length is fixed regardless of in_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    idx <= '0;
    else if (beat) idx <= last_beat ? '0 : idx + 1'b1;
  end

  // Sticky per-frame in_last mismatch flag, restarted on the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    err <= 1'b0;
    else if (beat) err <= (first_beat ? 1'b0 : err) | (in_last != last_beat);
  end

  top2_tracker #(
    .N           (N),
    .LABEL_W     (LABEL_W),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat       (beat),
    .first      (first_beat),
    .x          (in_data),
    .idx        (idx),
    .best       (best),
    .best_idx   (out_label),
    .second     (second),
    .second_idx (out_second)
  );

  // Tracker registers only change on accepted beats, so results hold steady
  // in HOLD. best >= second, so the low N bits of the N+1-bit signed
  // difference equal a plain N-bit subtraction in either mode.
  always_comb begin
    out_max    = best;
    out_margin = best - second;
    out_err    = err;
  end

endmodule

// File: tb/tb_label_argmax_stream.sv
// Directed bench for label_argmax_stream (unsigned and signed instances).
module tb_label_argmax_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = '0;

  logic       in_ready_u, out_valid_u, out_err_u;
  logic [3:0] out_label_u, out_second_u;
  logic [7:0] out_max_u, out_margin_u;
  logic       in_ready_s, out_valid_s, out_err_s;
  logic [3:0] out_label_s, out_second_s;
  logic [7:0] out_max_s, out_margin_s;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fa [10];
  logic [7:0] ft [10];
  logic [7:0] fs [10];
  logic [7:0] fu [10];

  always #5 clk = ~clk;

  label_argmax_stream #(.N(8), .NUM_LABELS(10), .LABEL_W(4), .SIGNED_MODE(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_label(out_label_u), .out_second(out_second_u), .out_max(out_max_u),
    .out_margin(out_margin_u), .out_err(out_err_u)
  );

  label_argmax_stream #(.N(8), .NUM_LABELS(10), .LABEL_W(4), .SIGNED_MODE(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_label(out_label_s), .out_second(out_second_s), .out_max(out_max_s),
    .out_margin(out_margin_s), .out_err(out_err_s)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_lab(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one 10-beat frame; afterwards the result must be valid one cycle later.
  task automatic send_frame(input logic [7:0] s [10], input int last_pos, input string tag);
    for (int i = 0; i < 10; i++) begin
      chk_bit({tag, "_in_ready"}, in_ready_u, 1'b1);
      chk_bit({tag, "_no_early_valid"}, out_valid_u, 1'b0);
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = (i == last_pos);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_bit({tag, "_out_valid_u"}, out_valid_u, 1'b1);
    chk_bit({tag, "_out_valid_s"}, out_valid_s, 1'b1);
    chk_bit({tag, "_hold_in_ready"}, in_ready_u, 1'b0);
  endtask

  task automatic check_u(input string tag, input logic [3:0] lab, input logic [3:0] sec,
                         input logic [7:0] mx, input logic [7:0] mg, input logic err);
    chk_lab({tag, "_u_label"}, out_label_u, lab);
    chk_lab({tag, "_u_second"}, out_second_u, sec);
    chk_val({tag, "_u_max"}, out_max_u, mx);
    chk_val({tag, "_u_margin"}, out_margin_u, mg);
    chk_bit({tag, "_u_err"}, out_err_u, err);
  endtask

  task automatic check_s(input string tag, input logic [3:0] lab, input logic [3:0] sec,
                         input logic [7:0] mx, input logic [7:0] mg, input logic err);
    chk_lab({tag, "_s_label"}, out_label_s, lab);
    chk_lab({tag, "_s_second"}, out_second_s, sec);
    chk_val({tag, "_s_max"}, out_max_s, mx);
    chk_val({tag, "_s_margin"}, out_margin_s, mg);
    chk_bit({tag, "_s_err"}, out_err_s, err);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_bit({tag, "_released"}, out_valid_u, 1'b0);
    chk_bit({tag, "_rdy_again"}, in_ready_u, 1'b1);
  endtask

  initial begin
    fa = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd0, 8'd2, 8'd5, 8'd8, 8'd4, 8'd6};
    ft = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    fs = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
    fu = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};

    // Reset state
    #1;
    chk_bit("rst_out_valid", out_valid_u, 1'b0);
    chk_bit("rst_in_ready", in_ready_u, 1'b0);
    check_u("rst", 4'd0, 4'd0, 8'd0, 8'd0, 1'b0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_bit("post_rst_in_ready", in_ready_u, 1'b1);

    // Basic unsigned frame
    send_frame(fa, 9, "basic");
    check_u("basic", 4'd1, 4'd7, 8'd9, 8'd1, 1'b0);
    check_s("basic", 4'd1, 4'd7, 8'd9, 8'd1, 1'b0);
    consume("basic");

    // All-equal scores: lowest indices win
    send_frame(ft, 9, "ties");
    check_u("ties", 4'd0, 4'd1, 8'd5, 8'd0, 1'b0);
    consume("ties");

    // Signed vs unsigned interpretation of the same bytes
    send_frame(fs, 9, "sgn");
    check_s("sgn", 4'd2, 4'd3, 8'h7F, 8'd127, 1'b0);
    check_u("sgn", 4'd1, 4'd4, 8'hFF, 8'h7E, 1'b0);
    consume("sgn");

    // Backpressure: result held, stray beats refused
    send_frame(fa, 9, "bp");
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(posedge clk); #1;
      chk_bit("bp_valid_held", out_valid_u, 1'b1);
      chk_bit("bp_in_ready_low", in_ready_u, 1'b0);
      check_u("bp_hold", 4'd1, 4'd7, 8'd9, 8'd1, 1'b0);
    end
    in_valid = 1'b0;
    consume("bp");
    send_frame(fu, 9, "bp_next");
    check_u("bp_next", 4'd9, 4'd8, 8'd100, 8'd10, 1'b0);
    consume("bp_next");

    // Early in_last: frame length unchanged, error flagged then cleared
    send_frame(fa, 4, "elast");
    check_u("elast", 4'd1, 4'd7, 8'd9, 8'd1, 1'b1);
    consume("elast");
    send_frame(fa, 9, "clean");
    check_u("clean", 4'd1, 4'd7, 8'd9, 8'd1, 1'b0);
    consume("clean");

    // Missing in_last on the final beat also flags
    send_frame(ft, 10, "nolast");
    chk_bit("nolast_err", out_err_u, 1'b1);
    consume("nolast");

    // Reset after beat 6 discards the partial frame
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hF0;
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    chk_bit("midrst_valid", out_valid_u, 1'b0);
    check_u("midrst", 4'd0, 4'd0, 8'd0, 8'd0, 1'b0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_bit("midrst_rdy", in_ready_u, 1'b1);
    send_frame(fu, 9, "after_rst");
    check_u("after_rst", 4'd9, 4'd8, 8'd100, 8'd10, 1'b0);
    check_s("after_rst", 4'd9, 4'd8, 8'd100, 8'd10, 1'b0);
    consume("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
